// File: rtl/cpu_bus_arbiter_if.sv
// Bus bundle between CPU masters / memory and the arbiter.
// The slave view is the arbiter; the master view is everything around it.
interface cpu_bus_arbiter_if #(
    parameter int NMASTERS = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
);
    logic [NMASTERS-1:0]          iReq;
    logic [NMASTERS-1:0]          iWe;
    logic [NMASTERS*DATA_W/8-1:0] iByteEnable;
    logic [NMASTERS*ADDR_W-1:0]   iAddress;
    logic [NMASTERS*DATA_W-1:0]   iWriteData;
    logic [NMASTERS-1:0]          oAck;
    logic [DATA_W-1:0]            oReadData;
    logic [NMASTERS-1:0]          oGrant;
    logic                         oBusy;
    logic                         oMemRE;
    logic                         oMemWE;
    logic [DATA_W/8-1:0]          oMemByteEnable;
    logic [ADDR_W-1:0]            oMemAddress;
    logic [DATA_W-1:0]            oMemWriteData;
    logic [DATA_W-1:0]            iMemReadData;

    modport slave (
        input  iReq, iWe, iByteEnable, iAddress, iWriteData, iMemReadData,
        output oAck, oReadData, oGrant, oBusy, oMemRE, oMemWE,
               oMemByteEnable, oMemAddress, oMemWriteData
    );

    modport master (
        output iReq, iWe, iByteEnable, iAddress, iWriteData, iMemReadData,
        input  oAck, oReadData, oGrant, oBusy, oMemRE, oMemWE,
               oMemByteEnable, oMemAddress, oMemWriteData
    );
endinterface

// File: rtl/cpu_bus_arbiter.sv
// Merges NMASTERS request/ack CPU ports onto one memory port, one transaction
// at a time, with fixed-priority or round-robin arbitration.
//
// state  | meaning
// IDLE   | no transaction; arbitrate and latch the winner's request
// ACCESS | first memory cycle (write strobe, or read start)
// WAIT   | read latency countdown, address held stable
// DONE   | ack pulse to the owner, bus released next cycle
module cpu_bus_arbiter #(
    parameter int NMASTERS = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter int RR_MODE  = 1
) (
    input logic iCLK,
    input logic iRST,
    cpu_bus_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t            state;
    logic [IDX_W-1:0]  rrPtr;
    logic [IDX_W-1:0]  winIdx;
    logic [IDX_W-1:0]  winner;
    logic [3:0]        latCnt;
    logic              anyReq;
    logic              lastCycle;
    logic              selWe;
    logic [BE_W-1:0]   selBe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;

    // Scan downward so the surviving hit is the first requester at/after rrPtr.
    // rrPtr never leaves 0 in fixed-priority mode, which makes this lowest-index-wins.
    always_comb begin
        winner = '0;
        for (int k = NMASTERS - 1; k >= 0; k--) begin
            if (bus.iReq[(int'(rrPtr) + k) % NMASTERS]) begin
                winner = IDX_W'((int'(rrPtr) + k) % NMASTERS);
            end
        end
    end

    assign anyReq  = |bus.iReq;
    assign selWe   = bus.iWe[winner];
    assign selBe   = bus.iByteEnable[int'(winner) * BE_W +: BE_W];
    assign selAddr = bus.iAddress[int'(winner) * ADDR_W +: ADDR_W];
    assign selData = bus.iWriteData[int'(winner) * DATA_W +: DATA_W];

    assign lastCycle = ((state == ACCESS) && (bus.oMemWE || (READ_LAT == 1))) ||
                       ((state == WAIT) && (latCnt == 4'd1));

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state              <= IDLE;
            rrPtr              <= '0;
            winIdx             <= '0;
            latCnt             <= '0;
            bus.oAck           <= '0;
            bus.oReadData      <= '0;
            bus.oGrant         <= '0;
            bus.oBusy          <= 1'b0;
            bus.oMemRE         <= 1'b0;
            bus.oMemWE         <= 1'b0;
            bus.oMemByteEnable <= '0;
            bus.oMemAddress    <= '0;
            bus.oMemWriteData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.oAck <= '0;
                    if (anyReq) begin
                        winIdx             <= winner;
                        bus.oGrant         <= {{(NMASTERS-1){1'b0}}, 1'b1} << winner;
                        bus.oBusy          <= 1'b1;
                        bus.oMemWE         <= selWe;
                        bus.oMemRE         <= ~selWe;
                        bus.oMemByteEnable <= selBe;
                        bus.oMemAddress    <= selAddr;
                        bus.oMemWriteData  <= selData;
                        state              <= ACCESS;
                    end
                end
                ACCESS, WAIT: begin
                    if (lastCycle) begin
                        if (bus.oMemRE) begin
                            bus.oReadData <= bus.iMemReadData;
                        end
                        bus.oMemRE         <= 1'b0;
                        bus.oMemWE         <= 1'b0;
                        bus.oMemByteEnable <= '0;
                        bus.oMemAddress    <= '0;
                        bus.oMemWriteData  <= '0;
                        bus.oAck           <= bus.oGrant;
                        state              <= DONE;
                    end else if (state == ACCESS) begin
                        latCnt <= 4'(READ_LAT - 1);
                        state  <= WAIT;
                    end else begin
                        latCnt <= latCnt - 4'd1;
                    end
                end
                DONE: begin
                    bus.oAck   <= '0;
                    bus.oGrant <= '0;
                    bus.oBusy  <= 1'b0;
                    if (RR_MODE != 0) begin
                        rrPtr <= (winIdx == IDX_W'(NMASTERS - 1)) ? '0 : winIdx + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
